// File: rtl/l2_bank_responder_if.sv
// ============================================================================
// Module   : l2_bank_responder_if
// Brief    : Crossbar-side request/response bus and bank-side port bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface l2_bank_responder_if #(
  parameter int ID_WIDTH   = 20,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int TAG_WIDTH  = BE_WIDTH
) ();

  // Request from the arbitration tree
  logic                  data_req_i;
  logic [ADDR_WIDTH-1:0] data_add_i;
  logic                  data_wen_i;
  logic [DATA_WIDTH-1:0] data_wdata_i;
  logic [BE_WIDTH-1:0]   data_be_i;
  logic [TAG_WIDTH-1:0]  data_tag_i;
  logic [ID_WIDTH-1:0]   data_ID_i;
  logic                  data_gnt_o;

  // Response toward the masters
  logic [ID_WIDTH-1:0]   data_r_valid_o;
  logic [DATA_WIDTH-1:0] data_r_rdata_o;
  logic [TAG_WIDTH-1:0]  data_r_rtag_o;

  // SRAM bank controller side
  logic                  mem_req_o;
  logic                  mem_gnt_i;
  logic [ADDR_WIDTH-1:0] mem_add_o;
  logic                  mem_wen_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [BE_WIDTH-1:0]   mem_be_o;
  logic                  mem_rvalid_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  logic                  err_o;

  modport slave (
    input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i,
    input  data_tag_i, data_ID_i,
    output data_gnt_o,
    output data_r_valid_o, data_r_rdata_o, data_r_rtag_o,
    output mem_req_o, mem_add_o, mem_wen_o, mem_wdata_o, mem_be_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output err_o
  );

  modport master (
    output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i,
    output data_tag_i, data_ID_i,
    input  data_gnt_o,
    input  data_r_valid_o, data_r_rdata_o, data_r_rtag_o,
    input  mem_req_o, mem_add_o, mem_wen_o, mem_wdata_o, mem_be_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  err_o
  );

endinterface

`default_nettype wire

// File: rtl/l2_bank_responder.sv
// ============================================================================
// Module   : l2_bank_responder
// Brief    : Bank-side responder; forwards granted requests, returns responses
//            in order as a one-hot valid vector.
// Revision : 1.0
// ============================================================================
`default_nettype none

module l2_bank_responder #(
  parameter int ID_WIDTH        = 20,
  parameter int ADDR_WIDTH      = 12,
  parameter int DATA_WIDTH      = 64,
  parameter int BE_WIDTH        = DATA_WIDTH / 8,
  parameter int TAG_WIDTH       = BE_WIDTH,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  l2_bank_responder_if.slave      bus
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // In-flight transaction tracking
  logic [ID_WIDTH-1:0]   id_mem_q  [MAX_OUTSTANDING];
  logic [ID_WIDTH-1:0]   id_mem_d  [MAX_OUTSTANDING];
  logic [TAG_WIDTH-1:0]  tag_mem_q [MAX_OUTSTANDING];
  logic [TAG_WIDTH-1:0]  tag_mem_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q,  count_d;

  // Registered response and error state
  logic [ID_WIDTH-1:0]   r_valid_q, r_valid_d;
  logic [DATA_WIDTH-1:0] r_rdata_q, r_rdata_d;
  logic [TAG_WIDTH-1:0]  r_rtag_q,  r_rtag_d;
  logic                  err_q,     err_d;

  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  // Explicit wrap so non-power-of-two depths cycle correctly
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  always_comb begin
    full  = (count_q == CNT_FULL);
    empty = (count_q == '0);
    push  = bus.data_req_i & bus.mem_gnt_i & ~full;
    pop   = bus.mem_rvalid_i & ~empty;
  end

  assign bus.mem_req_o      = bus.data_req_i & ~full;
  assign bus.data_gnt_o     = push;
  assign bus.mem_add_o      = bus.data_add_i;
  assign bus.mem_wen_o      = bus.data_wen_i;
  assign bus.mem_wdata_o    = bus.data_wdata_i;
  assign bus.mem_be_o       = bus.data_be_i;
  assign bus.data_r_valid_o = r_valid_q;
  assign bus.data_r_rdata_o = r_rdata_q;
  assign bus.data_r_rtag_o  = r_rtag_q;
  assign bus.err_o          = err_q;

  always_comb begin
    id_mem_d  = id_mem_q;
    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    r_valid_d = '0;
    r_rdata_d = r_rdata_q;
    r_rtag_d  = r_rtag_q;
    err_d     = err_q | (bus.mem_rvalid_i & empty);

    if (push) begin
      id_mem_d[wr_ptr_q]  = bus.data_ID_i;
      tag_mem_d[wr_ptr_q] = bus.data_tag_i;
      wr_ptr_d            = ptr_inc(wr_ptr_q);
    end

    if (pop) begin
      r_valid_d = id_mem_q[rd_ptr_q];
      r_rdata_d = bus.mem_rdata_i;
      r_rtag_d  = tag_mem_q[rd_ptr_q];
      rd_ptr_d  = ptr_inc(rd_ptr_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        id_mem_q[i]  <= '0;
        tag_mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      r_valid_q <= '0;
      r_rdata_q <= '0;
      r_rtag_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      id_mem_q  <= id_mem_d;
      tag_mem_q <= tag_mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      r_valid_q <= r_valid_d;
      r_rdata_q <= r_rdata_d;
      r_rtag_q  <= r_rtag_d;
      err_q     <= err_d;
    end
  end

endmodule

`default_nettype wire
